// File: rtl/sb_cfg_shadow.sv
`default_nettype none
// ============================================================================
// Module   : sb_cfg_shadow
// Purpose  : Switch block with a serial shadow config chain and atomic commit.
// Revision : 1.0
// ============================================================================
module sb_cfg_shadow #(
    parameter int CHAN_W = 10,
    parameter int NMUX   = 7,
    parameter int MUX_IN = 2,
    parameter int SEL_W  = 2
) (
    input  logic                     prog_clk,
    input  logic                     pReset,
    input  logic [CHAN_W-1:0]        chanx_right_in,
    input  logic [CHAN_W-1:0]        chany_bottom_in,
    input  logic [NMUX*MUX_IN-1:0]   mux_in_right,
    input  logic [NMUX*MUX_IN-1:0]   mux_in_bottom,
    input  logic                     ccff_head,
    input  logic                     cfg_shift_en,
    input  logic                     cfg_commit,
    output logic [CHAN_W-1:0]        chanx_right_out,
    output logic [CHAN_W-1:0]        chany_bottom_out,
    output logic                     ccff_tail,
    output logic                     cfg_valid,
    output logic                     cfg_done,
    output logic                     cfg_err
);

    localparam int CFG_BITS = 2 * NMUX * SEL_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] c_CNT_OVF  = CNT_W'(CFG_BITS + 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_ACTIVE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CFG_BITS-1:0]  r_shadow;
    logic [CFG_BITS-1:0]  r_active;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_valid;
    logic                 r_done;
    logic                 r_err;
    logic                 w_commit_ok;
    logic [NMUX-1:0]      w_mux_r;
    logic [NMUX-1:0]      w_mux_b;

    // Commit is judged on the pre-shift count, so a shift in the same cycle
    // always starts a fresh load at count 1.
    always_comb begin
        w_commit_ok = cfg_commit && (r_cnt == c_CNT_FULL);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (cfg_shift_en) begin
            w_state_nxt = S_LOADING;
            if (cfg_commit)
                w_cnt_nxt = CNT_W'(1);
            else if (r_cnt != c_CNT_OVF)
                w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (cfg_commit) begin
            w_state_nxt = (w_commit_ok || r_valid) ? S_ACTIVE : S_EMPTY;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= w_commit_ok;
            if (cfg_shift_en)
                r_shadow <= {r_shadow[CFG_BITS-2:0], ccff_head};
            if (w_commit_ok) begin
                r_active <= r_shadow;
                r_valid  <= 1'b1;
                r_err    <= 1'b0;
            end else if (cfg_commit) begin
                r_err <= 1'b1;
            end
        end
    end

    // Out-of-range selects and an unconfigured block both yield 0.
    for (genvar m = 0; m < NMUX; m++) begin : g_mux
        logic [SEL_W-1:0]  w_sel_r;
        logic [SEL_W-1:0]  w_sel_b;
        logic [MUX_IN-1:0] w_in_r;
        logic [MUX_IN-1:0] w_in_b;
        logic              w_bit_r;
        logic              w_bit_b;

        assign w_sel_r = r_active[m*SEL_W +: SEL_W];
        assign w_sel_b = r_active[(m+NMUX)*SEL_W +: SEL_W];
        assign w_in_r  = mux_in_right[m*MUX_IN +: MUX_IN];
        assign w_in_b  = mux_in_bottom[m*MUX_IN +: MUX_IN];

        always_comb begin
            w_bit_r = 1'b0;
            w_bit_b = 1'b0;
            for (int i = 0; i < MUX_IN; i++) begin
                if (r_valid && (w_sel_r == SEL_W'(i)))
                    w_bit_r = w_in_r[i];
                if (r_valid && (w_sel_b == SEL_W'(i)))
                    w_bit_b = w_in_b[i];
            end
        end

        assign w_mux_r[m] = w_bit_r;
        assign w_mux_b[m] = w_bit_b;
    end

    assign chanx_right_out[NMUX-1:0]  = w_mux_r;
    assign chany_bottom_out[NMUX-1:0] = w_mux_b;

    if (CHAN_W > NMUX) begin : g_pass
        assign chanx_right_out[CHAN_W-1:NMUX]  = chany_bottom_in[CHAN_W-NMUX-1:0];
        assign chany_bottom_out[CHAN_W-1:NMUX] = chanx_right_in[CHAN_W-NMUX-1:0];
    end

    // Upper incoming tracks have no destination in this tile.
    logic w_unused;
    assign w_unused = ^{chanx_right_in[CHAN_W-1:CHAN_W-NMUX],
                        chany_bottom_in[CHAN_W-1:CHAN_W-NMUX]};

    assign ccff_tail = r_shadow[CFG_BITS-1];
    assign cfg_valid = r_valid;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sb_cfg_shadow.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_cfg_shadow
// Purpose  : Scoreboard bench for sb_cfg_shadow against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_sb_cfg_shadow;

    localparam int CHAN_W   = 10;
    localparam int NMUX     = 7;
    localparam int MUX_IN   = 2;
    localparam int SEL_W    = 2;
    localparam int CFG_BITS = 2 * NMUX * SEL_W;

    logic                   prog_clk = 1'b0;
    logic                   pReset;
    logic [CHAN_W-1:0]      chanx_right_in;
    logic [CHAN_W-1:0]      chany_bottom_in;
    logic [NMUX*MUX_IN-1:0] mux_in_right;
    logic [NMUX*MUX_IN-1:0] mux_in_bottom;
    logic                   ccff_head;
    logic                   cfg_shift_en;
    logic                   cfg_commit;
    logic [CHAN_W-1:0]      chanx_right_out;
    logic [CHAN_W-1:0]      chany_bottom_out;
    logic                   ccff_tail;
    logic                   cfg_valid;
    logic                   cfg_done;
    logic                   cfg_err;

    sb_cfg_shadow #(
        .CHAN_W (CHAN_W),
        .NMUX   (NMUX),
        .MUX_IN (MUX_IN),
        .SEL_W  (SEL_W)
    ) u_dut (
        .prog_clk         (prog_clk),
        .pReset           (pReset),
        .chanx_right_in   (chanx_right_in),
        .chany_bottom_in  (chany_bottom_in),
        .mux_in_right     (mux_in_right),
        .mux_in_bottom    (mux_in_bottom),
        .ccff_head        (ccff_head),
        .cfg_shift_en     (cfg_shift_en),
        .cfg_commit       (cfg_commit),
        .chanx_right_out  (chanx_right_out),
        .chany_bottom_out (chany_bottom_out),
        .ccff_tail        (ccff_tail),
        .cfg_valid        (cfg_valid),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    logic tailq[$];

    logic [CFG_BITS-1:0] m_shadow;
    logic [CFG_BITS-1:0] m_active;
    int                  m_cnt;
    logic                m_valid;
    logic                m_err;
    logic                m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHAN_W-1:0] mdl_out(input logic bottom);
        logic [CHAN_W-1:0]      r;
        logic [SEL_W-1:0]       s;
        logic [NMUX*MUX_IN-1:0] mi;
        logic [CHAN_W-1:0]      pt;
        r  = '0;
        mi = bottom ? mux_in_bottom : mux_in_right;
        pt = bottom ? chanx_right_in : chany_bottom_in;
        for (int m = 0; m < NMUX; m++) begin
            s = m_active[(m + (bottom ? NMUX : 0))*SEL_W +: SEL_W];
            if (m_valid && int'(s) < MUX_IN)
                r[m] = mi[m*MUX_IN + int'(s)];
        end
        for (int k = 0; k < CHAN_W - NMUX; k++)
            r[NMUX+k] = pt[k];
        return r;
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_cnt    = 0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_done   = 1'b0;
        tailq.delete();
    endtask

    task automatic push_all();
        sbq.push_back('{"right_out",  32'(mdl_out(1'b0))});
        sbq.push_back('{"bottom_out", 32'(mdl_out(1'b1))});
        sbq.push_back('{"cfg_valid",  32'(m_valid)});
        sbq.push_back('{"cfg_err",    32'(m_err)});
        sbq.push_back('{"cfg_done",   32'(m_done)});
        sbq.push_back('{"ccff_tail",  32'(m_shadow[CFG_BITS-1])});
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got output %0h expected no output", obs);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic pop_all();
        pop_cmp(32'(chanx_right_out));
        pop_cmp(32'(chany_bottom_out));
        pop_cmp(32'(cfg_valid));
        pop_cmp(32'(cfg_err));
        pop_cmp(32'(cfg_done));
        pop_cmp(32'(ccff_tail));
    endtask

    task automatic rand_inputs();
        chanx_right_in  = CHAN_W'($urandom);
        chany_bottom_in = CHAN_W'($urandom);
        mux_in_right    = (NMUX*MUX_IN)'($urandom);
        mux_in_bottom   = (NMUX*MUX_IN)'($urandom);
    endtask

    // One clock: drive, predict post-edge state, push, clock, pop and compare.
    task automatic cycle(input logic sh, input logic hd, input logic cm);
        rand_inputs();
        cfg_shift_en = sh;
        ccff_head    = hd;
        cfg_commit   = cm;
        if (cm) begin
            if (m_cnt == CFG_BITS) begin
                m_active = m_shadow;
                m_done   = 1'b1;
                m_err    = 1'b0;
                m_valid  = 1'b1;
            end else begin
                m_done = 1'b0;
                m_err  = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
        if (sh) begin
            m_shadow = {m_shadow[CFG_BITS-2:0], hd};
            m_cnt    = cm ? 1 : ((m_cnt == CFG_BITS + 1) ? m_cnt : m_cnt + 1);
            tailq.push_back(hd);
        end else if (cm) begin
            m_cnt = 0;
        end
        push_all();
        @(posedge prog_clk);
        #1;
        pop_all();
        if (sh && tailq.size() == CFG_BITS)
            chk("tail_delay", 32'(ccff_tail), 32'(tailq.pop_front()));
        cfg_shift_en = 1'b0;
        cfg_commit   = 1'b0;
    endtask

    task automatic shift_word(input logic [CFG_BITS-1:0] w, input int n);
        for (int i = CFG_BITS - 1; i > CFG_BITS - 1 - n; i--)
            cycle(1'b1, w[i], 1'b0);
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 1'($urandom), 1'b0);
    endtask

    initial begin
        pReset       = 1'b0;
        ccff_head    = 1'b0;
        cfg_shift_en = 1'b0;
        cfg_commit   = 1'b0;
        model_reset();

        // Held in reset: muxes driven all-ones must still read 0.
        rand_inputs();
        mux_in_right  = '1;
        mux_in_bottom = '1;
        push_all();
        #3;
        pop_all();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            mux_in_right  = '1;
            mux_in_bottom = '1;
            push_all();
            #2;
            pop_all();
        end

        @(negedge prog_clk);
        pReset = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // All muxes select input 1, then commit.
        shift_word(28'h5555555, CFG_BITS);
        cycle(1'b0, 1'b0, 1'b1);
        chk("r0_is_in1", 32'(chanx_right_out[0]), 32'(mux_in_right[1]));
        chk("b0_is_in1", 32'(chany_bottom_out[0]), 32'(mux_in_bottom[1]));
        cycle(1'b0, 1'b0, 1'b0);

        // Short load is rejected, then a full load clears the error.
        shift_word(28'h0000000, CFG_BITS - 1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        shift_word(28'h0000000, CFG_BITS);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Reload while active: outputs keep the old selection until commit.
        shift_word(28'h0001555, CFG_BITS);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Out-of-range select on mux 0, then an overflowing load.
        shift_word(28'h5555557, CFG_BITS);
        cycle(1'b0, 1'b0, 1'b1);
        chk("sel3_zero", 32'(chanx_right_out[0]), 32'd0);
        shift_rand(CFG_BITS + 2);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a load.
        shift_rand(10);
        @(negedge prog_clk);
        #2;
        pReset = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(cfg_valid), 32'd0);
        chk("arst_err",   32'(cfg_err),   32'd0);
        chk("arst_done",  32'(cfg_done),  32'd0);
        chk("arst_tail",  32'(ccff_tail), 32'd0);
        chk("arst_rmux",  32'(chanx_right_out[NMUX-1:0]),  32'd0);
        chk("arst_bmux",  32'(chany_bottom_out[NMUX-1:0]), 32'd0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        pReset = 1'b1;

        // Fresh count after reset, then a shift coinciding with commit.
        shift_word(28'h5555555, CFG_BITS);
        cycle(1'b1, 1'b1, 1'b1);
        shift_rand(CFG_BITS - 1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
